// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter: SLL / SRL / SRA (+ ROL when PIPELINED_BARREL_SHIFTER_ROTATE_EN is defined).
// Latency: STAGES cycles from accept to data_out when out_ready is held high.
// Backpressure: a stage loads when empty or when its successor loads; in_ready is the stage-0 load condition.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake
//   execute               0 forces the result to zero (the transaction still flows)
//   opr, cntr             {opr,cntr}: 10 SLL, 00 SRL, 01 SRA, 11 ROL (macro) or zero
//   shamt, data_in        shift amount and operand
//   out_valid / out_ready output handshake; data_out is the result
//   busy                  any stage holds a valid transaction
//
// Optional feature macro: PIPELINED_BARREL_SHIFTER_ROTATE_EN (enables ROL for {opr,cntr}=11).
// Shift level k (shift by 2^k) is placed in stage floor(k*STAGES/SHAMT_W).

module pipelined_barrel_shifter #(
  parameter int WIDTH   = 32,
  parameter int STAGES  = 2,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               execute,
  input  logic               opr,
  input  logic               cntr,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  // Per-transaction control carried alongside the data through the pipe.
  typedef struct packed {
    logic               exe;
    logic [1:0]         op;
    logic [SHAMT_W-1:0] sh;
  } ctl_t;

  // Stage registers
  logic [STAGES-1:0] vld_q;
  logic [WIDTH-1:0]  dat_q [STAGES];
  ctl_t              ctl_q [STAGES];

  // Per-stage sources (what each stage would capture) and next data
  logic [STAGES-1:0] src_vld;
  logic [WIDTH-1:0]  src_dat [STAGES];
  ctl_t              src_ctl [STAGES];
  logic [WIDTH-1:0]  nxt_dat [STAGES];
  logic [STAGES-1:0] load;

  // Apply only the shift levels owned by stage 'stg'. SRA uses the current
  // MSB as fill; earlier levels never disturb it, so it is still the
  // operand's sign bit.
  function automatic logic [WIDTH-1:0] apply_levels(
    input logic [WIDTH-1:0] x,
    input ctl_t             c,
    input int               stg
  );
    logic [WIDTH-1:0] r;
    int n;
    r = x;
    for (int k = 0; k < SHAMT_W; k++) begin
      n = 1 << k;
      if (c.sh[k] && ((k * STAGES) / SHAMT_W == stg)) begin
        case (c.op)
          OP_SLL:  r = r << n;
          OP_SRL:  r = r >> n;
          OP_SRA:  r = $unsigned($signed(r) >>> n);
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
          OP_ROL:  r = (r << n) | (r >> (WIDTH - n));
`endif
          default: r = r;
        endcase
      end
    end
    return r;
  endfunction

  // Load chain, evaluated from the output end backwards so a drained
  // downstream slot propagates a load all the way to the input in one cycle.
  always_comb begin
    logic ld;
    load = '0;
    ld   = !vld_q[STAGES-1] || out_ready;
    load[STAGES-1] = ld;
    for (int s = STAGES - 2; s >= 0; s--) begin
      ld      = !vld_q[s] || ld;
      load[s] = ld;
    end
  end

  assign in_ready = load[0];

  // Stage sources and the combinational shift levels in front of each register
  always_comb begin
    src_vld        = '0;
    src_vld[0]     = in_valid;
    src_dat[0]     = data_in;
    src_ctl[0].exe = execute;
    src_ctl[0].op  = {opr, cntr};
    src_ctl[0].sh  = shamt;
    for (int s = 1; s < STAGES; s++) begin
      src_vld[s] = vld_q[s-1];
      src_dat[s] = dat_q[s-1];
      src_ctl[s] = ctl_q[s-1];
    end
    for (int s = 0; s < STAGES; s++) begin
      nxt_dat[s] = apply_levels(src_dat[s], src_ctl[s], s);
    end
    // Result zeroing happens as the last stage captures, so data_out stays a
    // plain register output.
    if (!src_ctl[STAGES-1].exe || (src_ctl[STAGES-1].op == OP_ROL && !ROT_EN)) begin
      nxt_dat[STAGES-1] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < STAGES; s++) begin
        dat_q[s] <= '0;
        ctl_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          vld_q[s] <= src_vld[s];
          // Payload only captured for real transactions; bubbles leave it untouched.
          if (src_vld[s]) begin
            dat_q[s] <= nxt_dat[s];
            ctl_q[s] <= src_ctl[s];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign data_out  = dat_q[STAGES-1];
  assign busy      = |vld_q;

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Bench for pipelined_barrel_shifter: three instances (STAGES = 2, 1, 5) share one
// stimulus stream; each has its own queue-based reference model and compare process.
// Directed literal cases run against the STAGES=2 instance.

module tb_pipelined_barrel_shifter;

  localparam int W    = 32;
  localparam int NDUT = 3;
  localparam int NEVER = 32'h7fff_ffff;

`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
  localparam logic [31:0] ROL_EXP = 32'h0000_0003;
`else
  localparam logic [31:0] ROL_EXP = 32'h0000_0000;
`endif

  typedef struct {
    logic [31:0] exp;
    int          acc;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        execute = 1'b0;
  logic        opr = 1'b0;
  logic        cntr = 1'b0;
  logic        out_ready = 1'b1;
  logic [4:0]  shamt = '0;
  logic [31:0] data_in = '0;

  logic        rdy_w  [NDUT];
  logic        vld_w  [NDUT];
  logic        busy_w [NDUT];
  logic [31:0] dat_w  [NDUT];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int free_since = NEVER;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: whole-amount shifts with plain arithmetic.
  function automatic logic [31:0] model(input logic [31:0] d, input logic o, input logic c,
                                        input logic e, input logic [4:0] s);
    logic [63:0] wide;
    if (!e) return 32'h0;
    case ({o, c})
      2'b10: return d << s;
      2'b00: return d >> s;
      2'b01: begin
        wide = {{32{d[31]}}, d} >> s;
        return wide[31:0];
      end
      default: begin
`ifdef PIPELINED_BARREL_SHIFTER_ROTATE_EN
        wide = {d, d} << s;
        return wide[63:32];
`else
        return 32'h0;
`endif
      end
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int ST = (g == 0) ? 2 : (g == 1) ? 1 : 5;
    item_t q[$];
    bit    was_stalled = 1'b0;

    pipelined_barrel_shifter #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_w[g]),
      .execute   (execute),
      .opr       (opr),
      .cntr      (cntr),
      .shamt     (shamt),
      .data_in   (data_in),
      .out_valid (vld_w[g]),
      .out_ready (out_ready),
      .data_out  (dat_w[g]),
      .busy      (busy_w[g])
    );

    // Compare process: outputs are sampled on the falling edge, i.e. the
    // values the next rising edge will act on.
    always @(negedge clk) begin
      item_t it;
      if (!rst_n) begin
        q.delete();
        was_stalled = 1'b0;
      end else begin
        check(busy_w[g] == (q.size() != 0), $sformatf("busy_s%0d", ST),
              {31'b0, busy_w[g]}, {31'b0, q.size() != 0});
        if (was_stalled)
          check(vld_w[g], $sformatf("held_valid_s%0d", ST), {31'b0, vld_w[g]}, 32'h1);
        if (vld_w[g]) begin
          check(q.size() != 0, $sformatf("spurious_out_s%0d", ST), dat_w[g], 32'h0);
          if (q.size() != 0) begin
            check(dat_w[g] == q[0].exp, $sformatf("data_s%0d", ST), dat_w[g], q[0].exp);
            if (out_ready) begin
              it = q.pop_front();
              if (it.acc >= free_since)
                check(cyc - it.acc == ST, $sformatf("latency_s%0d", ST), cyc - it.acc, ST);
            end
          end
        end
        was_stalled = vld_w[g] && !out_ready;
        if (in_valid && rdy_w[g])
          q.push_back('{exp: model(data_in, opr, cntr, execute, shamt), acc: cyc});
      end
    end
  end

  task automatic go_free();
    out_ready  = 1'b1;
    free_since = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int g = 0; g < NDUT; g++) begin
      check(!vld_w[g], "reset_out_valid", {31'b0, vld_w[g]}, 32'h0);
      check(dat_w[g] == 32'h0, "reset_data_out", dat_w[g], 32'h0);
      check(!busy_w[g], "reset_busy", {31'b0, busy_w[g]}, 32'h0);
    end
    go_free();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NDUT; g++)
      check(rdy_w[g], "reset_in_ready", {31'b0, rdy_w[g]}, 32'h1);
    @(posedge clk);
    #1;
    free_since = cyc;
  endtask

  // One op through the STAGES=2 instance with a literal expectation.
  task automatic run_op(input string name, input logic [31:0] d, input logic o, input logic c,
                        input logic e, input logic [4:0] s, input logic [31:0] exp);
    int k;
    data_in = d; opr = o; cntr = c; execute = e; shamt = s;
    in_valid = 1'b1;
    @(negedge clk);
    check(rdy_w[0], {name, "_accept"}, {31'b0, rdy_w[0]}, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!vld_w[0] && k < 10);
    check(vld_w[0] && k == 2, {name, "_latency"}, k, 2);
    check(dat_w[0] == exp, name, dat_w[0], exp);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid = 1'b0;
    go_free();
    while ((busy_w[0] || busy_w[1] || busy_w[2]) && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    check(!(busy_w[0] || busy_w[1] || busy_w[2]), "drain", t, 0);
  endtask

  // Four back-to-back ops with out_ready low for the first three cycles.
  task automatic backpressure();
    int acc;
    int t;
    acc = 0;
    t = 0;
    free_since = NEVER;
    out_ready = 1'b0;
    opr = 1'b0; cntr = 1'b0; execute = 1'b1;
    data_in = 32'hA5A5_0000; shamt = 5'd0;
    in_valid = 1'b1;
    while (acc < 4 && t < 30) begin
      @(negedge clk);
      if (t == 2) begin
        check(!rdy_w[0], "bp_in_ready_drop", {31'b0, rdy_w[0]}, 32'h0);
        check(acc == 2, "bp_held_count", acc, 2);
      end
      if (in_valid && rdy_w[0]) acc++;
      @(posedge clk);
      #1 t++;
      out_ready = (t >= 3);
      if (acc < 4) begin
        data_in = 32'hA5A5_0000 + 32'(acc * 16'h1111);
        shamt   = 5'(acc);
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check(acc == 4, "bp_accepts", acc, 4);
  endtask

  task automatic random_phase(input int n, input bit rand_ready);
    int r;
    if (rand_ready) free_since = NEVER;
    for (int i = 0; i < n; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      data_in  = $urandom;
      opr      = 1'($urandom_range(0, 1));
      cntr     = 1'($urandom_range(0, 1));
      execute  = ($urandom_range(0, 7) != 0);
      r = $urandom_range(0, 9);
      shamt    = (r == 0) ? 5'd0 : (r == 1) ? 5'd31 : 5'($urandom_range(0, 31));
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    do_reset();

    run_op("sll_1_by_31",   32'h0000_0001, 1'b1, 1'b0, 1'b1, 5'd31, 32'h8000_0000);
    run_op("sra_neg_by_4",  32'h8000_00F0, 1'b0, 1'b1, 1'b1, 5'd4,  32'hF800_000F);
    run_op("srl_by_4",      32'h8000_00F0, 1'b0, 1'b0, 1'b1, 5'd4,  32'h0800_000F);
    run_op("execute_zero",  32'h8000_00F0, 1'b0, 1'b1, 1'b0, 5'd4,  32'h0000_0000);
    run_op("rol_by_1",      32'h8000_0001, 1'b1, 1'b1, 1'b1, 5'd1,  ROL_EXP);
    run_op("shamt0_pass",   32'h1234_5678, 1'b0, 1'b1, 1'b1, 5'd0,  32'h1234_5678);
    run_op("sra_pos_by_28", 32'h7000_0000, 1'b0, 1'b1, 1'b1, 5'd28, 32'h0000_0007);
    run_op("srl_ones_31",   32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd31, 32'h0000_0001);

    backpressure();
    drain();

    // Reset while the pipes hold stalled work
    free_since = NEVER;
    out_ready = 1'b0;
    random_phase(6, 1'b0);
    do_reset();
    repeat (4) @(posedge clk);
    #1;

    random_phase(700, 1'b1);
    drain();
    go_free();
    random_phase(700, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
